// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_pkg
// Purpose  : Shared FSM/owner types and read-latency limits for the arbiter.
// Revision : 1.0
// ============================================================================
package data_mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;
  localparam int CNT_W          = 2;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin select; present only with DATA_MEM_ARB_ROUND_ROBIN_EN.
// Revision : 1.0
// ============================================================================
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
module rr_arbiter2
  import data_mem_arbiter_pkg::*;
(
  input  logic       req_core,
  input  logic       req_dbg,
  input  owner_t     last_owner,
  output logic [1:0] gnt          // bit 0 core, bit 1 debug
);

  always_comb begin
    gnt = 2'b00;
    if (req_core && req_dbg) begin
      gnt = (last_owner == OWN_CORE) ? 2'b10 : 2'b01;
    end else if (req_core) begin
      gnt = 2'b01;
    end else if (req_dbg) begin
      gnt = 2'b10;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Core/debug arbiter for the single-port data memory; ties are
//            round-robin with DATA_MEM_ARB_ROUND_ROBIN_EN, core-first otherwise.
// Revision : 1.0
// ============================================================================
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Out-of-range latencies are clamped so the wait counter always fits.
  localparam int RD_LAT_C = (RD_LATENCY < RD_LATENCY_MIN) ? RD_LATENCY_MIN :
                            (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT_C - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  owner_t                owner_q, owner_d;
  logic                  core_rvalid_q, core_rvalid_d;
  logic                  dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

  logic idle;
  logic gnt_core;
  logic gnt_dbg;
  logic rd_issue;

  // Grants and stall are combinational, so they are also forced low in reset.
  assign idle = n_reset & (state_q == ST_IDLE);

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  owner_t     last_owner_q, last_owner_d;
  logic [1:0] rr_gnt;

  rr_arbiter2 u_rr_arbiter2 (
    .req_core   (idle & core_req),
    .req_dbg    (idle & dbg_req),
    .last_owner (last_owner_q),
    .gnt        (rr_gnt)
  );

  assign gnt_core = rr_gnt[0];
  assign gnt_dbg  = rr_gnt[1];

  always_comb begin
    last_owner_d = last_owner_q;
    if (gnt_core) begin
      last_owner_d = OWN_CORE;
    end else if (gnt_dbg) begin
      last_owner_d = OWN_DBG;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      last_owner_q <= OWN_DBG;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign gnt_core = idle & core_req;
  assign gnt_dbg  = idle & dbg_req & ~core_req;
`endif

  assign mem_en    = gnt_core | gnt_dbg;
  assign mem_we    = gnt_dbg ? dbg_we : (gnt_core & core_we);
  assign mem_addr  = gnt_dbg ? dbg_addr : core_addr;
  assign mem_wdata = gnt_dbg ? dbg_wdata : core_wdata;
  assign rd_issue  = mem_en & ~mem_we;

  assign core_gnt    = gnt_core;
  assign dbg_gnt     = gnt_dbg;
  assign core_rvalid = core_rvalid_q;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign dbg_rdata   = dbg_rdata_q;
  assign core_stall  = n_reset & ((core_req & ~gnt_core) | (gnt_core & ~core_we) |
                                  ((state_q == ST_WAIT) & (owner_q == OWN_CORE)));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    core_rvalid_d = 1'b0;
    dbg_rvalid_d  = 1'b0;
    core_rdata_d  = core_rdata_q;
    dbg_rdata_d   = dbg_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_issue) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
          owner_d = gnt_dbg ? OWN_DBG : OWN_CORE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_DBG) begin
            dbg_rdata_d  = mem_rdata;
            dbg_rvalid_d = 1'b1;
          end else begin
            core_rdata_d  = mem_rdata;
            core_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      owner_q       <= OWN_CORE;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dbg_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      dbg_rdata_q   <= dbg_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Self-checking bench for data_mem_arbiter against a cycle-stamped
//            transaction model (honours DATA_MEM_ARB_ROUND_ROBIN_EN).
// Revision : 1.0
// ============================================================================
module tb_data_mem_arbiter;

  localparam int RD = 2;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_reset;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_gnt, core_rvalid, core_stall, dbg_gnt, dbg_rvalid;
  logic [31:0] core_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RD_LATENCY (RD)
  ) u_dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .core_stall  (core_stall),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory contents plus cycle stamps of outstanding events.
  logic [31:0] mem_arr [32];
  int          cyc;
  int          busy_until;
  int          rd_cyc;
  int          core_resp_cyc, dbg_resp_cyc, core_pend_until;
  logic [31:0] rd_val, core_resp_val, dbg_resp_val;
  logic [31:0] exp_core_rdata, exp_dbg_rdata;
  logic        last_dbg;

  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  int          c_prob, d_prob, we_prob;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_until      = cyc;
    rd_cyc          = -1;
    core_resp_cyc   = -1;
    dbg_resp_cyc    = -1;
    core_pend_until = -1;
    last_dbg        = 1'b1;
    exp_core_rdata  = '0;
    exp_dbg_rdata   = '0;
    c_req           = 1'b0;
    d_req           = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_core_gnt"},    32'(core_gnt),    32'd0);
    check_eq({tag, "_dbg_gnt"},     32'(dbg_gnt),     32'd0);
    check_eq({tag, "_mem_en"},      32'(mem_en),      32'd0);
    check_eq({tag, "_mem_we"},      32'(mem_we),      32'd0);
    check_eq({tag, "_core_stall"},  32'(core_stall),  32'd0);
    check_eq({tag, "_core_rvalid"}, 32'(core_rvalid), 32'd0);
    check_eq({tag, "_dbg_rvalid"},  32'(dbg_rvalid),  32'd0);
    check_eq({tag, "_core_rdata"},  core_rdata,       32'd0);
    check_eq({tag, "_dbg_rdata"},   dbg_rdata,        32'd0);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic run_cycle();
    logic        free, win_c, win_d, e_we, e_stall, e_crv, e_drv;
    logic [31:0] e_addr, e_wdata;
    if (!c_req && ($urandom_range(99) < 32'(c_prob))) begin
      c_req   = 1'b1;
      c_we    = ($urandom_range(99) < 32'(we_prob));
      c_addr  = 32'($urandom_range(31));
      c_wdata = $urandom;
    end
    if (!d_req && ($urandom_range(99) < 32'(d_prob))) begin
      d_req   = 1'b1;
      d_we    = ($urandom_range(99) < 32'(we_prob));
      d_addr  = 32'($urandom_range(31));
      d_wdata = $urandom;
    end
    core_req = c_req; core_we = c_we; core_addr = c_addr; core_wdata = c_wdata;
    dbg_req  = d_req; dbg_we  = d_we; dbg_addr  = d_addr; dbg_wdata  = d_wdata;
    mem_rdata = (cyc == rd_cyc) ? rd_val : $urandom;

    free    = (cyc >= busy_until);
    win_c   = free && c_req && (!d_req || !RR || last_dbg);
    win_d   = free && d_req && !win_c;
    e_we    = win_c ? c_we : d_we;
    e_addr  = win_c ? c_addr : d_addr;
    e_wdata = win_c ? c_wdata : d_wdata;
    e_stall = (c_req && !win_c) || (win_c && !c_we) || (cyc <= core_pend_until);
    e_crv   = (cyc == core_resp_cyc);
    e_drv   = (cyc == dbg_resp_cyc);
    if (e_crv) exp_core_rdata = core_resp_val;
    if (e_drv) exp_dbg_rdata = dbg_resp_val;

    #1;
    check_eq("core_gnt",    32'(core_gnt),    32'(win_c));
    check_eq("dbg_gnt",     32'(dbg_gnt),     32'(win_d));
    check_eq("mem_en",      32'(mem_en),      32'(win_c || win_d));
    check_eq("core_stall",  32'(core_stall),  32'(e_stall));
    check_eq("core_rvalid", 32'(core_rvalid), 32'(e_crv));
    check_eq("dbg_rvalid",  32'(dbg_rvalid),  32'(e_drv));
    check_eq("core_rdata",  core_rdata,       exp_core_rdata);
    check_eq("dbg_rdata",   dbg_rdata,        exp_dbg_rdata);
    if (win_c || win_d) begin
      check_eq("mem_we",   32'(mem_we), 32'(e_we));
      check_eq("mem_addr", mem_addr,    e_addr);
      if (e_we) check_eq("mem_wdata", mem_wdata, e_wdata);
    end

    if (win_c || win_d) begin
      if (e_we) begin
        mem_arr[e_addr[4:0]] = e_wdata;
      end else begin
        busy_until = cyc + RD + 1;
        rd_cyc     = cyc + RD;
        rd_val     = mem_arr[e_addr[4:0]];
        if (win_c) begin
          core_resp_cyc   = cyc + RD + 1;
          core_resp_val   = rd_val;
          core_pend_until = cyc + RD;
        end else begin
          dbg_resp_cyc = cyc + RD + 1;
          dbg_resp_val = rd_val;
        end
      end
      last_dbg = win_d;
    end
    if (win_c) c_req = 1'b0;
    if (win_d) d_req = 1'b0;

    @(negedge clk);
    cyc++;
  endtask

  initial begin
    n_reset = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
    mem_rdata = '0;
    c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_we = 1'b0; d_addr = '0; d_wdata = '0;
    c_prob = 0; d_prob = 0; we_prob = 0;
    cyc = 0;
    for (int i = 0; i < 32; i++) mem_arr[i] = $urandom;
    model_reset();

    // Power-on reset with live requests: every output must stay low.
    repeat (2) @(negedge clk);
    core_req = 1'b1; dbg_req = 1'b1;
    #1 check_reset_outputs("por");
    core_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    run_cycle();

    // Core write to 0x10.
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
    run_cycle();
    run_cycle();

    // Core read with the debug port joining one cycle later.
    mem_arr[5] = 32'h12345678;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd5;
    run_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd7; d_wdata = '0;
    repeat (5) run_cycle();

    // Both ports issuing reads back to back.
    c_prob = 100; d_prob = 100; we_prob = 0;
    repeat (15) run_cycle();
    c_prob = 0; d_prob = 0;
    repeat (8) run_cycle();

    // Debug port alone, reads back to back.
    d_prob = 100;
    repeat (12) run_cycle();
    d_prob = 0;
    repeat (6) run_cycle();

    // Random mixed traffic.
    c_prob = 35; d_prob = 35; we_prob = 50;
    repeat (400) run_cycle();
    c_prob = 0; d_prob = 0;
    repeat (12) run_cycle();

    // Reset one cycle after a core read grant aborts it.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'd9;
    run_cycle();
    n_reset = 1'b0;
    core_req = 1'b1; core_we = 1'b0;
    #1 check_reset_outputs("mid_read");
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    model_reset();
    repeat (8) run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
